// File: rtl/ysyx_22040088_ifu_pkg.sv
// Shared definitions for the NPC instruction fetch unit: FSM state encoding,
// the one-hot next-PC select codes driven by decode, and default geometry.
package ysyx_22040088_ifu_pkg;

  localparam int          IFU_XLEN     = 64;
  localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;

  // One-hot next-PC select from decode
  localparam logic [2:0] SEL_SEQ  = 3'b001;
  localparam logic [2:0] SEL_JAL  = 3'b010;
  localparam logic [2:0] SEL_JALR = 3'b100;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ysyx_22040088_nextpc.sv
// Next-PC selection for the fetch unit. Purely combinational: picks pc+4,
// the jal target or the jalr target (bit 0 cleared) from decode's one-hot
// select, and flags the result illegal when the select is not exactly one-hot
// or the chosen address is not word aligned.
module ysyx_22040088_nextpc
  import ysyx_22040088_ifu_pkg::*;
#(
  parameter int XLEN = IFU_XLEN
) (
  input  logic [XLEN-1:0] pc,
  input  logic [2:0]      sel_nextpc,
  input  logic [XLEN-1:0] jump_target,
  output logic [XLEN-1:0] next_pc,
  output logic            illegal
);

  logic sel_ok;

  // Select the candidate PC; pc+4 wraps naturally modulo 2^XLEN
  always_comb begin
    next_pc = pc;
    sel_ok  = 1'b1;
    case (sel_nextpc)
      SEL_SEQ:  next_pc = pc + XLEN'(4);
      SEL_JAL:  next_pc = jump_target;
      SEL_JALR: next_pc = {jump_target[XLEN-1:1], 1'b0};
      default:  sel_ok  = 1'b0;
    endcase
    illegal = !sel_ok || (next_pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/ysyx_22040088_ifu.sv
// Instruction fetch unit of the NPC core. Owns the PC, issues one request at a
// time to instruction memory, holds the returned instruction for decode and
// advances the PC on the decode handshake. An illegal select or a misaligned
// next PC parks the unit in S_HALT until reset.
// Optional feature: define YSYX_22040088_IFU_PERF_EN to add the
// perf_fetch_cnt / perf_stall_cnt performance counters.
module ysyx_22040088_ifu
  import ysyx_22040088_ifu_pkg::*;
#(
  parameter int              XLEN     = IFU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic [2:0]      sel_nextpc,
  input  logic [XLEN-1:0] jump_target,
  output logic            halted,
  output logic [XLEN-1:0] halt_pc
`ifdef YSYX_22040088_IFU_PERF_EN
  ,
  output logic [63:0]     perf_fetch_cnt,
  output logic [63:0]     perf_stall_cnt
`endif
);

  ifu_state_e      state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] next_pc;
  logic            next_illegal;

  assign imem_req_addr = pc;

  ysyx_22040088_nextpc #(
    .XLEN(XLEN)
  ) u_nextpc (
    .pc          (pc),
    .sel_nextpc  (sel_nextpc),
    .jump_target (jump_target),
    .next_pc     (next_pc),
    .illegal     (next_illegal)
  );

  // Fetch FSM: request -> wait for response -> hold for decode -> next PC or halt
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_REQ;
      pc             <= RESET_PC;
      inst           <= 32'h0;
      inst_pc        <= '0;
      inst_valid     <= 1'b0;
      imem_req_valid <= 1'b0;
      halted         <= 1'b0;
      halt_pc        <= '0;
    end else begin
      case (state)
        S_REQ: begin
          // After reset the request valid comes up one cycle late; from then
          // on it stays high with a stable address until memory accepts it.
          if (!imem_req_valid) begin
            imem_req_valid <= 1'b1;
          end else if (imem_req_ready) begin
            imem_req_valid <= 1'b0;
            state          <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            inst       <= imem_rsp_data;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_valid && inst_ready) begin
            inst_valid <= 1'b0;
            if (next_illegal) begin
              halted  <= 1'b1;
              halt_pc <= pc;
              state   <= S_HALT;
            end else begin
              pc             <= next_pc;
              imem_req_valid <= 1'b1;
              state          <= S_REQ;
            end
          end
        end
        S_HALT: begin
          imem_req_valid <= 1'b0;
          inst_valid     <= 1'b0;
          halted         <= 1'b1;
        end
        default: state <= S_HALT;
      endcase
    end
  end

`ifdef YSYX_22040088_IFU_PERF_EN
  // Performance counters: decode handshakes and cycles spent waiting on memory
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 64'd0;
      perf_stall_cnt <= 64'd0;
    end else if (state != S_HALT) begin
      if (state == S_HOLD && inst_valid && inst_ready) begin
        perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      end
      if ((state == S_REQ && !imem_req_ready) || state == S_WAIT) begin
        perf_stall_cnt <= perf_stall_cnt + 64'd1;
      end
    end
  end
`endif

endmodule
